uart_tx: RTL and testbench

UART transmitter: accepts a parallel byte through a valid/ready handshake and serialises it on `tx` as start bit, data LSB-first, optional parity, then one or two stop bits. It sits on the transmit side of the UART, opposite the receive path. It uses the same line convention: idle high, start bit low. Bit timing comes from an internal clocks-per-bit counter, so no external baud tick is needed.

---
 rtl/uart_defs.sv | 24 ++
 rtl/uart_baud_counter.sv | 28 ++
 rtl/uart_tx.sv | 122 ++++++++++++
 tb/tb_uart_tx.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_defs.sv
// Definitions shared by the UART transmit and receive paths: FSM states,
// line levels and parity modes.
package uart_defs;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  localparam logic PARITY_MODE_EVEN = 1'b0;
  localparam logic PARITY_MODE_ODD  = 1'b1;

  // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic parity_of(input logic [8:0] data, input logic mode);
    return (^data) ^ mode;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Clocks-per-bit counter: bit_done marks the last cycle of each serial bit.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_reg;

  assign bit_done = (cnt_reg == TERM);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (bit_done) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte in, start + data (LSB first) + optional
// parity + stop bits out on a registered, idle-high serial line.
module uart_tx
  import uart_defs::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
  localparam logic PAR_MODE = (PARITY_ODD != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;

  uart_state_t          state_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic                 parity_reg;
  logic                 bit_done;
  logic                 accept;
  logic                 clr;

  assign tx_ready = (state_reg == ST_IDLE) && en;
  assign accept   = tx_valid && tx_ready;
  // Holding the counter clear while idle makes the start bit a full period.
  assign clr      = (state_reg == ST_IDLE);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .bit_done(bit_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      shift_reg  <= '0;
      idx_reg    <= '0;
      parity_reg <= 1'b0;
      tx         <= LINE_IDLE;
      busy       <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          tx   <= LINE_IDLE;
          busy <= 1'b0;
          if (accept) begin
            shift_reg  <= tx_data;
            parity_reg <= parity_of(9'(tx_data), PAR_MODE);
            idx_reg    <= '0;
            tx         <= LINE_START;
            busy       <= 1'b1;
            state_reg  <= ST_START;
          end
        end
        ST_START: begin
          if (bit_done) begin
            tx        <= shift_reg[0];
            state_reg <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            if (idx_reg == LAST_DATA) begin
              idx_reg <= '0;
              if (PARITY_EN != 0) begin
                tx        <= parity_reg;
                state_reg <= ST_PARITY;
              end else begin
                tx        <= LINE_IDLE;
                state_reg <= ST_STOP;
              end
            end else begin
              shift_reg <= shift_reg >> 1;
              tx        <= shift_reg[1];
              idx_reg   <= idx_reg + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_done) begin
            tx        <= LINE_IDLE;
            state_reg <= ST_STOP;
          end
        end
        ST_STOP: begin
          // The bit index is reused here to count stop bits.
          if (bit_done) begin
            if (idx_reg == LAST_STOP) begin
              idx_reg   <= '0;
              busy      <= 1'b0;
              state_reg <= ST_IDLE;
            end else begin
              idx_reg <= idx_reg + 1'b1;
            end
          end
        end
        default: begin
          tx        <= LINE_IDLE;
          busy      <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances cover 8N1, 8E1, 8O1 and 8N2 at
// four clocks per bit; frames are traced cycle by cycle and compared to hand-built bit strings.
module tb_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] en;
  logic [3:0] valid;
  logic [3:0] ready;
  logic [3:0] tx;
  logic [3:0] busy;
  logic [7:0] tx_data;

  int checks = 0;
  int errors = 0;

  logic [127:0] tx_tr;
  logic [127:0] busy_tr;
  logic [127:0] rdy_tr;

  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_n1 (
    .clk(clk), .rst(rst), .en(en[0]), .tx_data(tx_data), .tx_valid(valid[0]),
    .tx_ready(ready[0]), .tx(tx[0]), .busy(busy[0]));

  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_e1 (
    .clk(clk), .rst(rst), .en(en[1]), .tx_data(tx_data), .tx_valid(valid[1]),
    .tx_ready(ready[1]), .tx(tx[1]), .busy(busy[1]));

  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_o1 (
    .clk(clk), .rst(rst), .en(en[2]), .tx_data(tx_data), .tx_valid(valid[2]),
    .tx_ready(ready[2]), .tx(tx[2]), .busy(busy[2]));

  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut_n2 (
    .clk(clk), .rst(rst), .en(en[3]), .tx_data(tx_data), .tx_valid(valid[3]),
    .tx_ready(ready[3]), .tx(tx[3]), .busy(busy[3]));

  // Offers one frame to instance d and records ncyc cycles, index 0 being the
  // cycle right after the accepting edge. Returns at the negedge of cycle ncyc.
  task automatic capture(input int d, input logic [7:0] data, input logic [7:0] data2,
                         input int drop_at, input int en_drop_at, input bit scramble,
                         input int ncyc);
    @(negedge clk);
    tx_data  = data;
    valid[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_data = data2;
    for (int k = 0; k < ncyc; k++) begin
      tx_tr[k]   = tx[d];
      busy_tr[k] = busy[d];
      rdy_tr[k]  = ready[d];
      if (k == drop_at) valid[d] = 1'b0;
      if (k == en_drop_at) en[d] = 1'b0;
      if (scramble) tx_data = 8'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 4'h0; valid = 4'h0; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (tx[d] !== 1'b1 || busy[d] !== 1'b0 || ready[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state dut%0d tx/busy/ready got %b%b%b want 100", d, tx[d], busy[d], ready[d]);
      end
    end
    rst = 1'b0; en = 4'hF;
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (ready[d] !== 1'b1 || tx[d] !== 1'b1) begin
        errors++;
        $display("FAIL reset_release dut%0d ready/tx got %b%b want 11", d, ready[d], tx[d]);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    string s = "0101001011";
    logic e;
    checks++;
    if (ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL basic_ready_idle got %b want 1", ready[0]);
    end
    capture(0, 8'hA5, 8'hA5, 0, -1, 1'b0, 40);
    for (int k = 0; k < 40; k++) begin
      e = (s[k/4] == "1");
      checks++;
      if (tx_tr[k] !== e || busy_tr[k] !== 1'b1 || rdy_tr[k] !== 1'b0) begin
        errors++;
        $display("FAIL basic_frame cyc %0d tx/busy/ready got %b%b%b want %b10", k, tx_tr[k], busy_tr[k], rdy_tr[k], e);
      end
    end
    checks++;
    if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL basic_end accept+41 tx/busy/ready got %b%b%b want 101", tx[0], busy[0], ready[0]);
    end
    $display("test_basic 0xA5 8N1 done");
  endtask

  task automatic test_parity();
    string se = "01110000011";
    string so = "01110000001";
    logic e;
    capture(1, 8'h07, 8'h07, 0, -1, 1'b0, 44);
    for (int k = 0; k < 44; k++) begin
      e = (se[k/4] == "1");
      checks++;
      if (tx_tr[k] !== e || busy_tr[k] !== 1'b1) begin
        errors++;
        $display("FAIL even_parity cyc %0d tx/busy got %b%b want %b1", k, tx_tr[k], busy_tr[k], e);
      end
    end
    checks++;
    if (busy[1] !== 1'b0 || ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL even_end busy/ready got %b%b want 01", busy[1], ready[1]);
    end
    capture(2, 8'h07, 8'h07, 0, -1, 1'b0, 44);
    for (int k = 0; k < 44; k++) begin
      e = (so[k/4] == "1");
      checks++;
      if (tx_tr[k] !== e || busy_tr[k] !== 1'b1) begin
        errors++;
        $display("FAIL odd_parity cyc %0d tx/busy got %b%b want %b1", k, tx_tr[k], busy_tr[k], e);
      end
    end
    checks++;
    if (busy[2] !== 1'b0 || ready[2] !== 1'b1) begin
      errors++;
      $display("FAIL odd_end busy/ready got %b%b want 01", busy[2], ready[2]);
    end
    $display("test_parity 0x07 even/odd done");
  endtask

  task automatic test_back_to_back();
    string s1 = "00000000011";
    string s2 = "01111111111";
    logic e;
    logic eb;
    capture(3, 8'h00, 8'hFF, 45, -1, 1'b0, 89);
    for (int k = 0; k < 89; k++) begin
      if (k < 44) begin
        e = (s1[k/4] == "1"); eb = 1'b1;
      end else if (k == 44) begin
        e = 1'b1; eb = 1'b0;
      end else begin
        e = (s2[(k-45)/4] == "1"); eb = 1'b1;
      end
      checks++;
      if (tx_tr[k] !== e || busy_tr[k] !== eb) begin
        errors++;
        $display("FAIL b2b_frames cyc %0d tx/busy got %b%b want %b%b", k, tx_tr[k], busy_tr[k], e, eb);
      end
    end
    checks++;
    if (rdy_tr[44] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap_ready got %b want 1", rdy_tr[44]);
    end
    checks++;
    if (tx[3] !== 1'b1 || busy[3] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end tx/busy got %b%b want 10", tx[3], busy[3]);
    end
    $display("test_back_to_back 0x00,0xFF 8N2 done");
  endtask

  task automatic test_enable();
    string s = "0010110101";
    logic e;
    en[0] = 1'b0; valid[0] = 1'b1; tx_data = 8'h81;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (ready[0] !== 1'b0 || tx[0] !== 1'b1 || busy[0] !== 1'b0) begin
        errors++;
        $display("FAIL en_low cyc %0d ready/tx/busy got %b%b%b want 010", k, ready[0], tx[0], busy[0]);
      end
    end
    valid[0] = 1'b0; en[0] = 1'b1;
    capture(0, 8'h5A, 8'h5A, 0, 10, 1'b0, 40);
    for (int k = 0; k < 40; k++) begin
      e = (s[k/4] == "1");
      checks++;
      if (tx_tr[k] !== e || busy_tr[k] !== 1'b1) begin
        errors++;
        $display("FAIL en_drop_frame cyc %0d tx/busy got %b%b want %b1", k, tx_tr[k], busy_tr[k], e);
      end
    end
    checks++;
    if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL en_drop_end tx/busy/ready got %b%b%b want 100", tx[0], busy[0], ready[0]);
    end
    en[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL en_restore_ready got %b want 1", ready[0]);
    end
    $display("test_enable 0x5A done");
  endtask

  task automatic test_reset_mid();
    string s = "0001111001";
    logic e;
    @(negedge clk);
    tx_data = 8'h00; valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (17) @(negedge clk);
    checks++;
    if (tx[0] !== 1'b0 || busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_bit3 tx/busy got %b%b want 01", tx[0], busy[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_abort tx/busy/ready got %b%b%b want 101", tx[0], busy[0], ready[0]);
    end
    rst = 1'b0;
    capture(0, 8'h3C, 8'h3C, 0, -1, 1'b0, 40);
    for (int k = 0; k < 40; k++) begin
      e = (s[k/4] == "1");
      checks++;
      if (tx_tr[k] !== e || busy_tr[k] !== 1'b1) begin
        errors++;
        $display("FAIL rst_mid_refill cyc %0d tx/busy got %b%b want %b1", k, tx_tr[k], busy_tr[k], e);
      end
    end
    checks++;
    if (tx[0] !== 1'b1 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_end tx/busy got %b%b want 10", tx[0], busy[0]);
    end
    $display("test_reset_mid abort + 0x3C done");
  endtask

  task automatic test_data_change();
    string s = "0110000111";
    logic e;
    capture(0, 8'hC3, 8'h00, 0, -1, 1'b1, 40);
    for (int k = 0; k < 40; k++) begin
      e = (s[k/4] == "1");
      checks++;
      if (tx_tr[k] !== e) begin
        errors++;
        $display("FAIL data_hold cyc %0d tx got %b want %b", k, tx_tr[k], e);
      end
    end
    checks++;
    if (tx[0] !== 1'b1 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL data_hold_end tx/busy got %b%b want 10", tx[0], busy[0]);
    end
    $display("test_data_change 0xC3 done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    test_data_change();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
